decode_imm_extend_stage: RTL
============================

Name: decode_imm_extend_stage

Overview:
- Parametrised, pipelined immediate-extension stage for the decode path of the MIPS pipeline.
- Takes a raw immediate field plus a mode, and produces a full-width operand: sign-extend, zero-extend, upper-load placement, or branch offset (sign-extend, then shift left 2).
- Registered output with valid/ready handshake, pipeline stall and flush, so it sits between the decode and execute pipeline registers.
- A tag (e.g. destination register or PC slice) travels alongside each result.

Parameters:
- IN_WIDTH, 16, immediate field width.
- OUT_WIDTH, 32, extended operand width; must satisfy OUT_WIDTH >= IN_WIDTH+2.
- PIPE_DEPTH, 1, number of register stages (1..4) between input and output.
- TAG_WIDTH, 5, sideband tag width carried with each result.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  kill all in-flight entries (branch mispredict / exception).
- in_valid  input  1  input entry present.
- in_ready  output  1  stage can accept an input this cycle.
- in_imm  input  IN_WIDTH  raw immediate field.
- in_mode  input  2  00 sign, 01 zero, 10 upper, 11 branch.
- in_tag  input  TAG_WIDTH  sideband tag.
- out_valid  output  1  out_data/out_tag hold a valid entry.
- out_ready  input  1  consumer accepts the output this cycle.
- out_data  output  OUT_WIDTH  extended operand.
- out_tag  output  TAG_WIDTH  tag matching out_data.

Behaviour:
- Extension rules, with imm = in_imm:
  - sign (00): {(OUT_WIDTH-IN_WIDTH){imm[IN_WIDTH-1]}, imm}.
  - zero (01): {(OUT_WIDTH-IN_WIDTH){0}, imm}.
  - upper (10): imm placed in bits [OUT_WIDTH-1 : OUT_WIDTH-IN_WIDTH], low bits 0.
  - branch (11): the sign result shifted left 2, low 2 bits 0; the top 2 bits of the sign result are discarded.
- Extension is computed combinationally on input and captured into stage 0. Later stages are pure delay registers carrying {valid, data, tag}.
- Pipeline advance: adv = !out_valid || out_ready. When adv=1, every stage shifts one position; when adv=0, every stage holds (global stall, no bubble collapsing).
- in_ready = adv. An input is accepted iff in_valid && in_ready. If adv=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- Latency: exactly PIPE_DEPTH cycles from acceptance to out_valid, when not stalled. Throughput is 1 per cycle under continuous out_ready.
- Output stability: while out_valid && !out_ready, out_data and out_tag are held unchanged.
- Data and tag registers load only on accept or advance. Their content when valid=0 is don't-care for checking, but must not be X after reset.
- flush: on the flush cycle all stage valid bits go to 0 at the next edge, and an input presented in the same cycle is dropped (in_ready still reads adv). Flush with out_ready=0 clears the held output.
- reset: synchronous. At the next edge all valids=0 and all data/tag=0, so out_valid=0, out_data=0, out_tag=0. Reset overrides flush and handshake. Reset asserted mid-stream discards all in-flight entries.
- Simultaneous out_ready and in_valid at a full pipe: the output is consumed and the input is accepted in the same cycle (no lost cycle).
- Invalid mode values cannot occur (the field is 2 bits and fully decoded).
- Compile-time check: OUT_WIDTH < IN_WIDTH+2 or PIPE_DEPTH outside 1..4 triggers an elaboration error.

Decomposition:
- Shared package decode_pkg:
  - mode localparams EXT_SIGN=2'b00, EXT_ZERO=2'b01, EXT_UPPER=2'b10, EXT_BRANCH=2'b11;
  - typedef ext_mode_t (2-bit).
- One natural sub-module: decode_imm_extend_core, combinational (imm, mode) -> data, parametrised by IN_WIDTH/OUT_WIDTH.
- The top level holds the stage register array and the handshake/flush logic.

Test Plan:
- Defaults, out_ready=1: sign 0x8004 -> out_data 0xFFFF8004 one cycle later; zero 0x8004 -> 0x00008004; tags 3 and 4 returned in order.
- upper 0x1234 -> 0x12340000; branch 0xFFFF -> 0xFFFFFFFC; branch 0x0001 -> 0x00000004.
- Backpressure: accept 0x0010, hold out_ready=0 for 3 cycles -> out_valid=1, out_data 0x00000010 stable, in_ready=0; release -> consumed, and the next input is accepted in the same cycle.
- PIPE_DEPTH=3, stream 4 entries: first out_valid 3 cycles after the first accept; flush in cycle 2 -> out_valid stays 0 and no flushed entry ever appears; a post-flush input emerges 3 cycles later.
- Reset mid-stream (2 entries in flight, stalled) -> next edge out_valid=0, out_data=0, out_tag=0, in_ready=1.
- Random mode/imm/tag with random out_ready against a scoreboard model -> every accepted entry emerges exactly once, in order, with the correct extension.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode-path definitions.
// Immediate extension modes used by the decode stages.
package decode_pkg;

    typedef logic [1:0] ext_mode_t;

    localparam ext_mode_t EXT_SIGN   = 2'b00;
    localparam ext_mode_t EXT_ZERO   = 2'b01;
    localparam ext_mode_t EXT_UPPER  = 2'b10;
    localparam ext_mode_t EXT_BRANCH = 2'b11;

endpackage

// File: rtl/decode_imm_extend_core.sv
// Combinational immediate extension.
// Maps a raw immediate and a mode to a full-width operand.
module decode_imm_extend_core
    import decode_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic [IN_WIDTH-1:0]  imm,
    input  logic [1:0]           mode,
    output logic [OUT_WIDTH-1:0] data
);

    localparam int PAD = OUT_WIDTH - IN_WIDTH;

    logic [OUT_WIDTH-1:0] sext;

    assign sext = {{PAD{imm[IN_WIDTH-1]}}, imm};

    always_comb begin
        data = sext;
        unique case (1'b1)
            mode == EXT_SIGN:   data = sext;
            mode == EXT_ZERO:   data = {{PAD{1'b0}}, imm};
            mode == EXT_UPPER:  data = {imm, {PAD{1'b0}}};
            // Word offset: top two sign bits fall off.
            mode == EXT_BRANCH: data = {sext[OUT_WIDTH-3:0], 2'b00};
            default:            data = sext;
        endcase
    end

endmodule

// File: rtl/decode_imm_extend_stage.sv
// Pipelined immediate-extension stage between decode and execute.
// Global-stall shift pipe carrying {valid, data, tag}.
module decode_imm_extend_stage
    import decode_pkg::*;
#(
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 32,
    parameter int PIPE_DEPTH = 1,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_imm,
    input  logic [1:0]           in_mode,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0] out_tag
);

    if (OUT_WIDTH < IN_WIDTH + 2 || PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_params
        $error("decode_imm_extend_stage: illegal parameters");
    end

    logic                 valid_q [PIPE_DEPTH];
    logic [OUT_WIDTH-1:0] data_q  [PIPE_DEPTH];
    logic [TAG_WIDTH-1:0] tag_q   [PIPE_DEPTH];
    logic [OUT_WIDTH-1:0] ext_data;
    logic                 adv;

    decode_imm_extend_core #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .data (ext_data)
    );

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = valid_q[PIPE_DEPTH-1];
    assign out_data  = data_q[PIPE_DEPTH-1];
    assign out_tag   = tag_q[PIPE_DEPTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            if (adv) begin
                valid_q[0] <= in_valid;
                data_q[0]  <= ext_data;
                tag_q[0]   <= in_tag;
                for (int i = 1; i < PIPE_DEPTH; i++) begin
                    valid_q[i] <= valid_q[i-1];
                    data_q[i]  <= data_q[i-1];
                    tag_q[i]   <= tag_q[i-1];
                end
            end
            // Flush wins over the shift, including the entry being accepted.
            if (flush) begin
                for (int i = 0; i < PIPE_DEPTH; i++) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

endmodule
